mac_row_ws: RTL and testbench
=============================

Name: mac_row_ws

Overview:
- Parametrised weight-stationary MAC row: a chain of `col` processing elements (PEs).
- Activation/weight data and a 3-bit instruction enter at the west edge and ripple east, one PE per cycle.
- Each PE holds a stationary weight, adds its product to the partial sum arriving from the north, and drives the result south.
- Additions over a plain MAC row: selectable signed activations, per-column enable mask, weight clear, execute counter, optional saturation. Tiled vertically inside the PE array.

Parameters:
- bw, 4, activation/weight width in bits.
- psum_bw, 16, partial-sum width in bits; must be ≥ 2*bw+1.
- col, 8, number of PEs in the row.
- act_signed, 0, 1 = activations are two's complement; 0 = unsigned. Weights are always two's complement.
- cnt_bw, 16, execute-counter width in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- in_w  input  bw  west activation/weight data.
- inst_w  input  3  instruction: [0] kernel load, [1] execute, [2] weight clear.
- in_n  input  psum_bw*col  north partial sums; column j at [psum_bw*(j+1)-1 : psum_bw*j].
- col_en  input  col  per-column enable; bit j gates PE j.
- out_s  output  psum_bw*col  registered south partial sums, same packing as in_n.
- valid  output  col  valid[j] is high for the cycle in which out_s column j holds a fresh execute result.
- exec_cnt  output  cnt_bw  number of executes completed by PE col-1.

Behaviour:
- Reset (reset=0, async) clears all per-PE registers:
  - data pipe a_q, instruction pipe i_q, weight w_q, partial sum p_q, valid v_q.
  - exec_cnt=0. All outputs read 0 while reset is held.
- Propagation:
  - PE0 sees in_w/inst_w combinationally. PE j (j≥1) sees PE j-1's a_q/i_q.
  - Every PE registers its seen data/instruction into a_q/i_q every cycle, independent of col_en.
  - Net effect: PE j sees the west token j cycles after PE0.
- Per PE j at each rising edge, with its seen instruction inst and data a:
  - col_en[j]=0: w_q, p_q hold; v_q<=0. Forwarding continues.
  - inst[2]=1: w_q<=0. Priority over inst[0].
  - else inst[0]=1: w_q<=a.
  - inst[1]=1: p_q <= in_n[j] + ext(a)*w_q (using the old w_q); v_q<=1.
  - inst[1]=0: p_q holds; v_q<=0.
  - inst[0] and inst[1] together: execute uses the old weight, and the new weight is loaded in the same cycle.
- Arithmetic:
  - ext(a) is a sign- or zero-extension of a per act_signed.
  - The product is computed at 2*bw+1 bits, sign-extended to psum_bw, and added modulo 2^psum_bw (wrap) unless SAT_EN is defined.
- Outputs: out_s[j]=p_q, valid[j]=v_q.
- Latency: inst_w[1] high at cycle t produces valid[j] high at cycle t+j+1 and holds the result for that cycle only; out_s keeps the value afterwards.
- exec_cnt:
  - Increments when v_q of PE col-1 is 1; wraps at 2^cnt_bw.
  - Synchronous clear when an inst[2] token reaches PE col-1 (clear has priority over increment in that cycle).
- Reset mid-stream: in-flight tokens are discarded; no partial results are emitted after release.
- in_n is sampled only on execute. X on in_n in non-execute cycles must not propagate.

Optional Feature:
- Macro MAC_ROW_SAT_EN.
- Defined: the adder saturates to signed psum_bw limits (+2^(psum_bw-1)-1 / -2^(psum_bw-1)). Adds output sat_flag (col bits), each bit high with valid[j] when that result clipped.
- Undefined: wrap-around add; no sat_flag port.

Test Plan:
- Reset then idle, act_signed=0: out_s=0, valid=0, exec_cnt=0 for 20 cycles; async assert mid-cycle clears outputs immediately.
- Load weight 3 (4'b0011) for all 8 cols via 8 staggered load tokens; then execute with in_w=5, in_n all 10 -> out_s[j]=25 with valid[j] at cycle t+j+1; exec_cnt=1.
- Weight -2 (4'b1110), act 4'b1111:
  - act_signed=0 -> out_s=-30 (0xFFE2) with in_n=0.
  - act_signed=1 -> +2.
- col_en=8'b1111_0101, execute -> valid only on cols 0,2,4-7; cols 1,3 keep prior out_s; data still reaches col 7.
- Simultaneous load+execute at PE0 (old w=3, in_w=2, in_n=0) -> out=6; next execute with in_w=1 -> out=2. Clear token -> next execute yields in_n unchanged; exec_cnt returns to 0 after clear reaches col 7.
- MAC_ROW_SAT_EN, psum_bw=16: in_n=32760, w=7, a=7 -> out_s=32767, sat_flag=1. Same stimulus without the macro -> 32809 wraps to -32727, 16'h8029.

Source files
------------

// File: rtl/mac_row_ws.sv
// mac_row_ws: weight-stationary MAC row built from a chain of `col` PEs.
//
// An activation/weight token and a 3-bit instruction enter PE0 from the west
// and ripple east by one PE per cycle. Each PE keeps a stationary weight,
// adds its product to the partial sum from the north, and drives it south.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   in_w      west activation/weight data (bw bits)
//   inst_w    instruction: [0] kernel load, [1] execute, [2] weight clear
//   in_n      north partial sums, column j at [psum_bw*(j+1)-1 : psum_bw*j]
//   col_en    per-column enable, bit j gates PE j
//   out_s     registered south partial sums, same packing as in_n
//   valid     valid[j] high for the cycle out_s column j holds a fresh result
//   exec_cnt  number of executes completed by PE col-1
//   sat_flag  (MAC_ROW_SAT_EN only) high with valid[j] when that result clipped
//
// Build option: define MAC_ROW_SAT_EN for a saturating adder; otherwise the
// partial-sum add wraps modulo 2^psum_bw.
module mac_row_ws #(
  parameter int bw         = 4,
  parameter int psum_bw    = 16,
  parameter int col        = 8,
  parameter int act_signed = 0,
  parameter int cnt_bw     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [bw-1:0]          in_w,
  input  logic [2:0]             inst_w,
  input  logic [psum_bw*col-1:0] in_n,
  input  logic [col-1:0]         col_en,
  output logic [psum_bw*col-1:0] out_s,
  output logic [col-1:0]         valid,
  output logic [cnt_bw-1:0]      exec_cnt
`ifdef MAC_ROW_SAT_EN
  ,
  output logic [col-1:0]         sat_flag
`endif
);

  localparam int PB   = 2 * bw + 1;
  // PE col-1's forwarded token feeds nothing, so only col-1 pipe stages exist.
  localparam int PIPE = (col > 1) ? col - 1 : 1;

  logic [bw-1:0]      a_q [PIPE];
  logic [2:0]         i_q [PIPE];
  logic [bw-1:0]      a_sn [col];
  logic [2:0]         i_sn [col];
  logic [bw-1:0]      w_q [col];
  logic [bw-1:0]      w_d [col];
  logic [psum_bw-1:0] p_q [col];
  logic [psum_bw-1:0] p_d [col];
  logic [col-1:0]     v_q, v_d;
  logic [cnt_bw-1:0]  cnt_q, cnt_d;
`ifdef MAC_ROW_SAT_EN
  logic [col-1:0]     sf_q, sf_d;
`endif

  // ext(a) * w at 2*bw+1 bits, sign-extended to psum_bw.
  function automatic logic [psum_bw-1:0] prod_ext(input logic [bw-1:0] a,
                                                  input logic [bw-1:0] w);
    logic signed [bw:0]   ax;
    logic signed [PB-1:0] prod;
    ax   = (act_signed != 0) ? {a[bw-1], a} : {1'b0, a};
    prod = ax * $signed(w);
    return psum_bw'(prod);
  endfunction

`ifdef MAC_ROW_SAT_EN
  function automatic logic add_ovf(input logic [psum_bw-1:0] n,
                                   input logic [psum_bw-1:0] pe);
    logic [psum_bw-1:0] s;
    s = n + pe;
    return (n[psum_bw-1] == pe[psum_bw-1]) && (s[psum_bw-1] != n[psum_bw-1]);
  endfunction

  function automatic logic [psum_bw-1:0] add_sat(input logic [psum_bw-1:0] n,
                                                 input logic [psum_bw-1:0] pe);
    logic [psum_bw-1:0] s;
    s = n + pe;
    if (add_ovf(n, pe))
      s = n[psum_bw-1] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    return s;
  endfunction
`endif

  always_comb begin
    a_sn[0] = in_w;
    i_sn[0] = inst_w;
    for (int unsigned j = 1; j < col; j++) begin
      a_sn[j] = a_q[j-1];
      i_sn[j] = i_q[j-1];
    end
  end

  always_comb begin
    v_d = '0;
`ifdef MAC_ROW_SAT_EN
    sf_d = '0;
`endif
    for (int unsigned j = 0; j < col; j++) begin
      w_d[j] = w_q[j];
      p_d[j] = p_q[j];
      if (col_en[j]) begin
        if (i_sn[j][2])
          w_d[j] = '0;
        else if (i_sn[j][0])
          w_d[j] = a_sn[j];
        // Execute uses the weight held before this edge, even on load+execute.
        if (i_sn[j][1]) begin
`ifdef MAC_ROW_SAT_EN
          p_d[j]  = add_sat(in_n[psum_bw*j +: psum_bw], prod_ext(a_sn[j], w_q[j]));
          sf_d[j] = add_ovf(in_n[psum_bw*j +: psum_bw], prod_ext(a_sn[j], w_q[j]));
`else
          p_d[j]  = in_n[psum_bw*j +: psum_bw] + prod_ext(a_sn[j], w_q[j]);
`endif
          v_d[j] = 1'b1;
        end
      end
    end
  end

  // Clear arriving at the last PE wins over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (i_sn[col-1][2])
      cnt_d = '0;
    else if (v_q[col-1])
      cnt_d = cnt_q + cnt_bw'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned j = 0; j < PIPE; j++) begin
        a_q[j] <= '0;
        i_q[j] <= '0;
      end
      for (int unsigned j = 0; j < col; j++) begin
        w_q[j] <= '0;
        p_q[j] <= '0;
      end
      v_q   <= '0;
      cnt_q <= '0;
`ifdef MAC_ROW_SAT_EN
      sf_q  <= '0;
`endif
    end else begin
      for (int unsigned j = 0; j < PIPE; j++) begin
        a_q[j] <= a_sn[j];
        i_q[j] <= i_sn[j];
      end
      for (int unsigned j = 0; j < col; j++) begin
        w_q[j] <= w_d[j];
        p_q[j] <= p_d[j];
      end
      v_q   <= v_d;
      cnt_q <= cnt_d;
`ifdef MAC_ROW_SAT_EN
      sf_q  <= sf_d;
`endif
    end
  end

  always_comb begin
    out_s = '0;
    for (int unsigned j = 0; j < col; j++)
      out_s[psum_bw*j +: psum_bw] = p_q[j];
  end

  assign valid    = v_q;
  assign exec_cnt = cnt_q;
`ifdef MAC_ROW_SAT_EN
  assign sat_flag = sf_q;
`endif

endmodule

// File: tb/tb_mac_row_ws.sv
module tb_mac_row_ws;
  localparam int BW   = 4;
  localparam int PSUM = 16;
  localparam int COL  = 8;
  localparam int CNTW = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [BW-1:0]       in_w;
  logic [2:0]          inst_w;
  logic [PSUM*COL-1:0] in_n;
  logic [COL-1:0]      col_en;
  logic [PSUM*COL-1:0] out_u, out_sg;
  logic [COL-1:0]      val_u, val_sg;
  logic [CNTW-1:0]     cnt_u, cnt_sg;
`ifdef MAC_ROW_SAT_EN
  logic [COL-1:0]      sf_u, sf_sg;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_row_ws #(.bw(BW), .psum_bw(PSUM), .col(COL), .act_signed(0), .cnt_bw(CNTW)) u_uns (
    .clk(clk), .reset(rst_n), .in_w(in_w), .inst_w(inst_w), .in_n(in_n),
    .col_en(col_en), .out_s(out_u), .valid(val_u), .exec_cnt(cnt_u)
`ifdef MAC_ROW_SAT_EN
    , .sat_flag(sf_u)
`endif
  );

  mac_row_ws #(.bw(BW), .psum_bw(PSUM), .col(COL), .act_signed(1), .cnt_bw(CNTW)) u_sgn (
    .clk(clk), .reset(rst_n), .in_w(in_w), .inst_w(inst_w), .in_n(in_n),
    .col_en(col_en), .out_s(out_sg), .valid(val_sg), .exec_cnt(cnt_sg)
`ifdef MAC_ROW_SAT_EN
    , .sat_flag(sf_sg)
`endif
  );

  typedef struct {
    logic [2:0]  inst;
    logic [3:0]  a;
    logic [15:0] n;
    logic        nx;
    logic        en;
    logic [15:0] exp_out;
    logic        exp_v;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_w = 3'd0;
    in_w   = '0;
  endtask

  task automatic set_n(input logic [15:0] v);
    in_n = {COL{v}};
  endtask

  function automatic logic [15:0] colv(input logic [PSUM*COL-1:0] v, input int j);
    return v[PSUM*j +: PSUM];
  endfunction

  initial begin
    logic [COL-1:0] mask;
    logic [COL-1:0] ev;

    tbl[0]  = '{3'd6, 4'd5,  16'd100,  1'b0, 1'b1, 16'd135,  1'b1};
    tbl[1]  = '{3'd0, 4'd9,  16'd0,    1'b1, 1'b1, 16'd135,  1'b0};
    tbl[2]  = '{3'd1, 4'hF,  16'd0,    1'b1, 1'b1, 16'd135,  1'b0};
    tbl[3]  = '{3'd2, 4'd2,  16'd50,   1'b0, 1'b1, 16'd48,   1'b1};
    tbl[4]  = '{3'd2, 4'd3,  16'd0,    1'b0, 1'b0, 16'd48,   1'b0};
    tbl[5]  = '{3'd1, 4'd5,  16'd0,    1'b1, 1'b0, 16'd48,   1'b0};
    tbl[6]  = '{3'd2, 4'd4,  16'd1000, 1'b0, 1'b1, 16'd996,  1'b1};
    tbl[7]  = '{3'd3, 4'd6,  16'd0,    1'b0, 1'b1, 16'hFFFA, 1'b1};
    tbl[8]  = '{3'd2, 4'hF,  16'd0,    1'b0, 1'b1, 16'd90,   1'b1};
    tbl[9]  = '{3'd2, 4'd8,  16'hFFF0, 1'b0, 1'b1, 16'd32,   1'b1};
    tbl[10] = '{3'd5, 4'd3,  16'd0,    1'b1, 1'b1, 16'd32,   1'b0};
    tbl[11] = '{3'd2, 4'hF,  16'd7,    1'b0, 1'b1, 16'd7,    1'b1};

    rst_n = 1'b0; idle(); in_n = '0; col_en = '1;

    // Reset held, then idle.
    repeat (3) step();
    chk("rst_out", out_u, '0);
    chk("rst_valid", val_u, '0);
    chk("rst_cnt", cnt_u, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_out", out_u, '0);
      chk("idle_valid", val_u, '0);
      chk("idle_cnt", cnt_u, '0);
    end

    // Load weight 3 everywhere, then execute a=5 with in_n=10.
    inst_w = 3'd1; in_w = 4'd3; step(); idle();
    repeat (8) step();
    set_n(16'd10);
    inst_w = 3'd2; in_w = 4'd5; step(); idle();
    for (int k = 1; k <= COL; k++) begin
      if (k > 1) step();
      ev = COL'(1) << (k - 1);
      chk("exec_valid", val_u, ev);
      chk("exec_out", colv(out_u, k - 1), 16'd25);
    end
    step();
    chk("exec_cnt1", cnt_u, 16'd1);
    chk("exec_cnt1_s", cnt_sg, 16'd1);
    chk("exec_valid_off", val_u, '0);
    chk("exec_hold", out_u, {COL{16'd25}});

    // Weight -2, activation 4'b1111: unsigned vs signed.
    inst_w = 3'd1; in_w = 4'hE; step(); idle();
    repeat (8) step();
    set_n(16'd0);
    inst_w = 3'd2; in_w = 4'hF; step(); idle();
    chk("neg_u_c0", colv(out_u, 0), 16'hFFE2);
    chk("neg_s_c0", colv(out_sg, 0), 16'd2);
    chk("neg_v_c0", val_sg[0], 1'b1);
    repeat (7) step();
    chk("neg_u_c7", colv(out_u, 7), 16'hFFE2);
    chk("neg_s_c7", colv(out_sg, 7), 16'd2);
    step();
    chk("neg_cnt2", cnt_u, 16'd2);

    // Column-enable mask.
    mask = 8'b1111_0101;
    col_en = mask;
    set_n(16'd100);
    inst_w = 3'd2; in_w = 4'd1; step(); idle();
    for (int k = 1; k <= COL; k++) begin
      if (k > 1) step();
      ev = (COL'(1) << (k - 1)) & mask;
      chk("mask_valid", val_u, ev);
    end
    for (int j = 0; j < COL; j++)
      chk("mask_out", colv(out_u, j), mask[j] ? 16'd98 : 16'hFFE2);
    step();
    chk("mask_cnt3", cnt_u, 16'd3);
    col_en = '1;

    // Simultaneous load+execute, then clear racing an increment at col 7.
    inst_w = 3'd1; in_w = 4'd3; step(); idle();
    repeat (8) step();
    set_n(16'd0);
    inst_w = 3'd3; in_w = 4'd2; step();
    chk("ldex_out", colv(out_u, 0), 16'd6);
    inst_w = 3'd2; in_w = 4'd1; step(); idle();
    chk("ldex_next", colv(out_u, 0), 16'd2);
    repeat (8) step();
    chk("ldex_cnt5", cnt_u, 16'd5);

    inst_w = 3'd2; in_w = 4'd1; step();
    chk("pre_clr_out", colv(out_u, 0), 16'd2);
    inst_w = 3'd4; in_w = 4'd0; step();
    chk("clr_valid", val_u[0], 1'b0);
    set_n(16'd10);
    inst_w = 3'd2; in_w = 4'd7; step(); idle();
    chk("post_clr_out", colv(out_u, 0), 16'd10);
    repeat (5) step();
    chk("race_valid7", val_u[7], 1'b1);
    chk("race_cnt5", cnt_u, 16'd5);
    step();
    chk("clr_cnt0", cnt_u, 16'd0);
    step();
    chk("clr_c7_out", colv(out_u, 7), 16'd10);
    step();
    chk("clr_cnt1", cnt_u, 16'd1);

    // Overflow at column 0: 32760 + 7*7.
    inst_w = 3'd1; in_w = 4'd7; step(); idle(); step();
    in_n = '0; in_n[15:0] = 16'd32760;
    inst_w = 3'd2; in_w = 4'd7; step(); idle();
`ifdef MAC_ROW_SAT_EN
    chk("sat_out", colv(out_u, 0), 16'h7FFF);
    chk("sat_flag", sf_u[0], 1'b1);
`else
    chk("wrap_out", colv(out_u, 0), 16'h8029);
`endif

    // Column-0 vector table.
    for (int i = 0; i < 12; i++) begin
      inst_w = tbl[i].inst;
      in_w   = tbl[i].a;
      col_en = {COL{tbl[i].en}};
      if (tbl[i].nx) in_n = 'x;
      else           set_n(tbl[i].n);
      step();
      chk($sformatf("tbl%0d_out", i), colv(out_u, 0), tbl[i].exp_out);
      chk($sformatf("tbl%0d_valid", i), val_u[0], tbl[i].exp_v);
    end
    idle(); col_en = '1; set_n(16'd5);

    // Asynchronous reset mid-cycle with a token in flight.
    inst_w = 3'd2; in_w = 4'd1; step(); idle(); step();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_out", out_u, '0);
    chk("async_valid", val_u, '0);
    chk("async_cnt", cnt_u, '0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("post_rst_valid", val_u, '0);
    end
    chk("post_rst_out", out_u, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
